// File: rtl/kernel_sink_pkg.sv
// Shared types and helpers for the kernel output sink: FSM states, MISR polynomial, nibble fold.
package kernel_sink_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sink_state_e;

   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

   function automatic logic [3:0] fold_nibble(input logic [7:0] x);
      return x[7:4] ^ x[3:0];
   endfunction

endpackage

// File: rtl/sink_fifo.sv
// Register FIFO buffering kernel output words; push/pop must already be qualified by the caller.
module sink_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int FILL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [FILL_W-1:0]     fill,
   output logic                  full,
   output logic                  empty
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0]     fill_q, fill_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign fill    = fill_q;
   assign full    = (fill_q == FILL_W'(FIFO_DEPTH));
   assign empty   = (fill_q == '0);

endmodule

// File: rtl/kernel_out_sink.sv
// Consumer of the kernel ap_fifo output stream: buffering, backpressure, nibble fold, run tracking.
// Optional run signature MISR is built only when OUT_MISR_EN is defined; otherwise misr_sig is 0.
//
//   state | meaning
//   IDLE  | waiting for ap_start rising edge; pops here are protocol errors
//   RUN   | counting popped words toward EXP_WORDS
//   DONE  | single cycle asserting run_done, then back to IDLE
module kernel_out_sink
   import kernel_sink_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int EXP_WORDS  = 4096,
   parameter int CNT_WIDTH  = 13
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   input  logic [DATA_WIDTH-1:0] out_din,
   input  logic                  out_write,
   output logic                  out_full_n,
   input  logic                  sink_ready,
   output logic [3:0]            data_out,
   output logic                  data_valid,
   output logic                  run_done,
   output logic                  word_err,
   output logic [31:0]           misr_sig
);
   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

   logic [FILL_W-1:0]     fill;
   logic                  full, empty;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  push, pop, overflow;

   assign out_full_n = (fill < FILL_W'(FIFO_DEPTH));
   assign push       = out_write & out_full_n;
   assign overflow   = out_write & full;
   assign pop        = ~empty & sink_ready;

   sink_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FILL_W     (FILL_W)
   ) u_fifo (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .push     (push),
      .pop      (pop),
      .din      (out_din),
      .rd_data  (rd_data),
      .fill     (fill),
      .full     (full),
      .empty    (empty)
   );

   sink_state_e          state_q, state_d;
   logic                 start_q, start_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 s1_vld_q, s1_vld_d;
   logic [7:0]           s1_xor_q, s1_xor_d;
   logic                 s2_vld_q, s2_vld_d;
   logic [3:0]           s2_nib_q, s2_nib_d;
   logic [7:0]           byte_xor;
   logic                 start_rise, count_pop;

   assign start_d    = ap_start;
   assign start_rise = ap_start & ~start_q;

   always_comb begin
      byte_xor = '0;
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
         byte_xor = byte_xor ^ rd_data[b*8 +: 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q | overflow;
      count_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_rise) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (pop && cnt_q != CNT_WIDTH'(EXP_WORDS)) begin
               count_pop = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_d == CNT_WIDTH'(EXP_WORDS)) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Words arriving outside a run are still shown on the pins but flagged.
      if (pop && state_q != RUN) begin
         err_d = 1'b1;
      end
      s1_vld_d = pop;
      s1_xor_d = pop ? byte_xor : '0;
      s2_vld_d = s1_vld_q;
      s2_nib_d = s1_vld_q ? fold_nibble(s1_xor_q) : '0;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         s1_vld_q <= 1'b0;
         s1_xor_q <= '0;
         s2_vld_q <= 1'b0;
         s2_nib_q <= '0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         s1_vld_q <= s1_vld_d;
         s1_xor_q <= s1_xor_d;
         s2_vld_q <= s2_vld_d;
         s2_nib_q <= s2_nib_d;
      end
   end

   assign data_valid = s2_vld_q;
   assign data_out   = s2_nib_q;
   assign run_done   = (state_q == DONE);
   assign word_err   = err_q;

`ifdef OUT_MISR_EN
   logic [31:0] misr_q, misr_d, misr_word;

   always_comb begin
      misr_word = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         misr_word[i % 32] = misr_word[i % 32] ^ rd_data[i];
      end
      misr_d = misr_q;
      if (state_q == IDLE && start_rise) begin
         misr_d = '0;
      end else if (count_pop) begin
         misr_d = {misr_q[30:0], 1'b0} ^ (misr_q[31] ? MISR_POLY : 32'h0) ^ misr_word;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         misr_q <= '0;
      end else begin
         misr_q <= misr_d;
      end
   end

   assign misr_sig = misr_q;
`else
   assign misr_sig = '0;
`endif

endmodule

// File: tb/tb_kernel_out_sink.sv
// Randomized bench for kernel_out_sink against a queue-based behavioural model of the sink.
module tb_kernel_out_sink;
   localparam int EXP = 4096;
   localparam logic [31:0] POLY = 32'h04C1_1DB7;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        ap_start = 1'b0;
   logic [31:0] out_din = '0;
   logic        out_write = 1'b0;
   logic        out_full_n;
   logic        sink_ready = 1'b0;
   logic [3:0]  data_out;
   logic        data_valid;
   logic        run_done;
   logic        word_err;
   logic [31:0] misr_sig;

   kernel_out_sink dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .ap_start   (ap_start),
      .out_din    (out_din),
      .out_write  (out_write),
      .out_full_n (out_full_n),
      .sink_ready (sink_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .run_done   (run_done),
      .word_err   (word_err),
      .misr_sig   (misr_sig)
   );

   always #5 ap_clk = ~ap_clk;

   int n_checks = 0;
   int n_err    = 0;

   // behavioural model
   logic [31:0] q[$];
   logic        m_pv1, m_pv2;
   logic [3:0]  m_pd1, m_pd2;
   logic        m_err, m_run, m_done, m_prev_start;
   int          m_cnt;
   logic [31:0] m_misr;

   logic [31:0] arr [EXP];
   logic        start_lvl = 1'b0;
   int          dv_cnt, rd_cnt;
   logic [3:0]  first_do;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_fold(input logic [31:0] d);
      logic [3:0] n = '0;
      for (int i = 0; i < 32; i++) n[i % 4] = n[i % 4] ^ d[i];
      return n;
   endfunction

   task automatic model_clear();
      q.delete();
      m_pv1 = 0; m_pv2 = 0; m_pd1 = '0; m_pd2 = '0;
      m_err = 0; m_run = 0; m_done = 0; m_prev_start = 0;
      m_cnt = 0; m_misr = '0;
   endtask

   task automatic cycle(input logic w, input logic [31:0] d, input logic sr);
      logic push, pop, was_run, was_done, was_idle;
      logic [31:0] word;
      logic [31:0] exp_misr;
      out_write = w; out_din = d; sink_ready = sr; ap_start = start_lvl;
      @(negedge ap_clk);
`ifdef OUT_MISR_EN
      exp_misr = m_misr;
`else
      exp_misr = '0;
`endif
      chk("full_n", 32'(out_full_n), 32'(q.size() < 4));
      chk("data_valid", 32'(data_valid), 32'(m_pv2));
      chk("data_out", 32'(data_out), 32'(m_pd2));
      chk("run_done", 32'(run_done), 32'(m_done));
      chk("word_err", 32'(word_err), 32'(m_err));
      chk("misr_sig", misr_sig, exp_misr);
      if (data_valid) begin
         if (dv_cnt == 0) first_do = data_out;
         dv_cnt++;
      end
      if (run_done) rd_cnt++;
      push = w && (q.size() < 4);
      if (w && q.size() >= 4) m_err = 1;
      pop  = (q.size() > 0) && sr;
      word = '0;
      if (pop) word = q.pop_front();
      m_pv2 = m_pv1; m_pd2 = m_pd1;
      m_pv1 = pop;   m_pd1 = pop ? ref_fold(word) : 4'h0;
      was_run = m_run; was_done = m_done; was_idle = !m_run && !m_done;
      if (pop && !was_run) m_err = 1;
      if (was_idle && start_lvl && !m_prev_start) begin
         m_run = 1; m_cnt = 0; m_misr = '0;
      end
      if (was_run && pop) begin
         m_misr = {m_misr[30:0], 1'b0} ^ (m_misr[31] ? POLY : 32'h0) ^ word;
         m_cnt++;
         if (m_cnt == EXP) begin
            m_run = 0; m_done = 1;
         end
      end
      if (was_done) m_done = 0;
      m_prev_start = start_lvl;
      if (push) q.push_back(d);
      @(posedge ap_clk); #1;
   endtask

   task automatic do_reset();
      ap_rst_n = 0; out_write = 0; sink_ready = 0; ap_start = 0; start_lvl = 0;
      #2;
      chk("rst_full_n", 32'(out_full_n), 32'd1);
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_run_done", 32'(run_done), 32'd0);
      chk("rst_word_err", 32'(word_err), 32'd0);
      chk("rst_misr", misr_sig, 32'd0);
      model_clear();
      @(negedge ap_clk); ap_rst_n = 1;
      @(posedge ap_clk); #1;
      dv_cnt = 0; rd_cnt = 0;
   endtask

   task automatic arm();
      start_lvl = 0; cycle(0, '0, 1);
      start_lvl = 1; cycle(0, '0, 1);
   endtask

   task automatic feed(input int n, input bit rnd, input int flip_idx);
      int sent = 0;
      int guard = 0;
      while (sent < n && guard < 20 * n + 100) begin
         logic w, sr;
         logic [31:0] d;
         sr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         w  = (q.size() < 4) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
         d  = arr[sent];
         if (sent == flip_idx) d[5] = ~d[5];
         cycle(w, d, sr);
         if (w) sent++;
         guard++;
      end
      chk("feed_bound", sent, n);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(0, '0, 1);
   endtask

   initial begin
      logic [31:0] sig_a, sig_b, sig_c;
      for (int i = 0; i < EXP; i++) arr[i] = $urandom;
      arr[0] = 32'h1234_5678;
      #1;
      do_reset();

      // full run at one word per cycle, first word checks the fold
      arm();
      feed(EXP, 0, -1);
      drain(8);
      chk("run1_valid_count", dv_cnt, EXP);
      chk("run1_done_count", rd_cnt, 1);
      chk("run1_err", 32'(word_err), 32'd0);
      chk("fold_12345678", 32'(first_do), 32'h8);

      // backpressure: honoured hold, then forced overflow
      do_reset();
      arm();
      for (int i = 0; i < 4; i++) cycle(1, arr[i], 0);
      chk("full_after4", 32'(out_full_n), 32'd0);
      cycle(q.size() < 4, arr[4], 0);
      chk("hold_no_err", 32'(word_err), 32'd0);
      cycle(1, arr[5], 0);
      chk("forced_err", 32'(word_err), 32'd1);
      drain(8);
      chk("bp_valid_count", dv_cnt, 4);

      // words without a run
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, arr[i + 10], 1);
      drain(6);
      chk("idle_valid_count", dv_cnt, 3);
      chk("idle_err", 32'(word_err), 32'd1);
      chk("idle_no_done", rd_cnt, 0);

      // reset mid-run, then a full run under random handshake
      do_reset();
      arm();
      feed(100, 0, -1);
      do_reset();
      arm();
      feed(EXP, 1, -1);
      drain(8);
      chk("run2_valid_count", dv_cnt, EXP);
      chk("run2_done_count", rd_cnt, 1);
      chk("run2_err", 32'(word_err), 32'd0);

`ifdef OUT_MISR_EN
      do_reset(); arm(); feed(EXP, 0, -1); drain(8); sig_a = misr_sig;
      arm(); feed(EXP, 1, -1); drain(8); sig_b = misr_sig;
      arm(); feed(EXP, 0, 777); drain(8); sig_c = misr_sig;
      chk("misr_repeat", sig_b, sig_a);
      n_checks++;
      assert (sig_c !== sig_a) else begin
         n_err++;
         $error("FAIL misr_flip observed=%h expected_not=%h", sig_c, sig_a);
      end
`else
      sig_a = '0; sig_b = '0; sig_c = '0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
